// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and driver for the common data bus.
// Shares a single broadcast path between N result producers (0 ALU, 1 mul,
// 2 div, 3 load/store). Each cycle, at most one request is accepted. The
// accepted result is registered onto the broadcast outputs.
//
// Ports:
//   clk        single clock, rising-edge
//   RST        synchronous active-high reset
//   require    per-requester result-valid, held until accepted
//   labelIn    requester i label in [i*LABEL_W +: LABEL_W]
//   dataIn     requester i data  in [i*DATA_W  +: DATA_W]
//   requireAC  one-hot combinational accept (zero while RST)
//   BCEN       registered broadcast valid
//   BClabel    registered broadcast label
//   BCdata     registered broadcast data
//   bcCount    broadcasts since reset, wraps modulo 2^16
//   protoErr   sticky flag: a request carrying label 0 was accepted
module cdb_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned LABEL_W = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [N-1:0]         require,
  input  logic [N*LABEL_W-1:0] labelIn,
  input  logic [N*DATA_W-1:0]  dataIn,
  output logic [N-1:0]         requireAC,
  output logic                 BCEN,
  output logic [LABEL_W-1:0]   BClabel,
  output logic [DATA_W-1:0]    BCdata,
  output logic [15:0]          bcCount,
  output logic                 protoErr
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W:0]   N_L  = (PTR_W+1)'(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   win_idx;
  logic [N-1:0]       win_oh;
  logic               win_vld;
  logic [LABEL_W-1:0] win_label;
  logic [DATA_W-1:0]  win_data;

  // Search from ptr upward, wrapping modulo N; the first active request wins.
  always_comb begin
    sum     = '0;
    win_idx = '0;
    win_oh  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= N_L) sum = sum - N_L;
      if (win_oh == '0 && require[sum[PTR_W-1:0]]) begin
        win_idx                 = sum[PTR_W-1:0];
        win_oh[sum[PTR_W-1:0]] = 1'b1;
      end
    end
  end

  assign win_vld   = |win_oh;
  assign requireAC = RST ? '0 : win_oh;
  assign ptr_nxt   = (win_idx == LAST) ? '0 : win_idx + 1'b1;

  // One-hot AND-OR mux keeps label/data out of any combinational output path.
  always_comb begin
    win_label = '0;
    win_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_label = win_label | labelIn[i*LABEL_W +: LABEL_W];
        win_data  = win_data  | dataIn[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ptr      <= '0;
      BCEN     <= 1'b0;
      BClabel  <= '0;
      BCdata   <= '0;
      bcCount  <= '0;
      protoErr <= 1'b0;
    end else if (win_vld) begin
      ptr     <= ptr_nxt;
      BCEN    <= 1'b1;
      BClabel <= win_label;
      BCdata  <= win_data;
      bcCount <= bcCount + 16'd1;
      if (win_label == '0) protoErr <= 1'b1;
    end else begin
      BCEN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a
// behavioural model (rotating-priority search, modular counter).
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         RST;
  logic [3:0]   require;
  logic [15:0]  labelIn;
  logic [127:0] dataIn;
  logic [3:0]   requireAC;
  logic         BCEN;
  logic [3:0]   BClabel;
  logic [31:0]  BCdata;
  logic [15:0]  bcCount;
  logic         protoErr;

  cdb_arbiter #(.N(4), .LABEL_W(4), .DATA_W(32)) dut (
    .clk(clk), .RST(RST), .require(require), .labelIn(labelIn),
    .dataIn(dataIn), .requireAC(requireAC), .BCEN(BCEN), .BClabel(BClabel),
    .BCdata(BCdata), .bcCount(bcCount), .protoErr(protoErr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_bcen = 1'b0;
  logic [3:0]  m_label = '0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] req, input int p);
    for (int k = 0; k < 4; k++) begin
      if (req[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [3:0] req,
                      input logic [15:0] lbl, input logic [127:0] dat);
    int w;
    logic [3:0] exp_ac;
    @(negedge clk);
    RST = rst; require = req; labelIn = lbl; dataIn = dat;
    #1;
    w = winner(req, m_ptr);
    exp_ac = (rst || w < 0) ? 4'b0000 : 4'(1 << w);
    check("requireAC", 64'(requireAC), 64'(exp_ac));
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_bcen = 1'b0; m_label = '0; m_data = '0; m_err = 1'b0;
    end else if (w >= 0) begin
      m_bcen  = 1'b1;
      m_label = lbl[w*4 +: 4];
      m_data  = dat[w*32 +: 32];
      m_ptr   = (w + 1) % 4;
      m_cnt   = (m_cnt + 1) % 65536;
      if (m_label == 4'd0) m_err = 1'b1;
    end else begin
      m_bcen = 1'b0;
    end
    @(posedge clk);
    #1;
    check("BCEN",     64'(BCEN),     64'(m_bcen));
    check("BClabel",  64'(BClabel),  64'(m_label));
    check("BCdata",   64'(BCdata),   64'(m_data));
    check("bcCount",  64'(bcCount),  64'(m_cnt));
    check("protoErr", 64'(protoErr), 64'(m_err));
  endtask

  localparam logic [15:0]  LBL_1234 = 16'h4321;
  localparam logic [127:0] DAT_ALL  = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};

  logic [3:0]  p_lbl [4];
  logic [31:0] p_dat [4];
  logic        pend  [4];

  initial begin
    RST = 1'b1; require = '0; labelIn = '0; dataIn = '0;

    // reset with requests present: nothing accepted
    step(1'b1, 4'b1111, LBL_1234, DAT_ALL);
    step(1'b1, 4'b0000, '0, '0);

    // single request from mul
    step(1'b0, 4'b0010, 16'h0050, {64'd0, 32'h0000_1234, 32'd0});
    check("single_bcdata", 64'(BCdata), 64'h1234);
    step(1'b0, 4'b0000, '0, '0);
    check("single_idle", 64'(BCEN), 64'd0);
    check("single_cnt", 64'(bcCount), 64'd1);

    // all four from reset: ALU, mul, div, ls, ALU
    step(1'b1, 4'b0000, '0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, LBL_1234, DAT_ALL);

    // fairness: ALU and div alternate
    step(1'b1, 4'b0000, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0101, LBL_1234, DAT_ALL);

    // reset mid-stream, then ls alone wins
    step(1'b0, 4'b0010, LBL_1234, DAT_ALL);
    step(1'b1, 4'b0010, LBL_1234, DAT_ALL);
    step(1'b0, 4'b1000, LBL_1234, DAT_ALL);

    // protocol error: ls with label 0; flag stays until reset
    step(1'b0, 4'b1000, 16'h0321, {32'h0000_DEAD, 96'd0});
    check("perr_label", 64'(BClabel), 64'd0);
    step(1'b0, 4'b0001, LBL_1234, DAT_ALL);
    check("perr_sticky", 64'(protoErr), 64'd1);
    step(1'b1, 4'b0000, '0, '0);

    // randomized: requesters hold until accepted, occasional resets
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; p_lbl[i] = '0; p_dat[i] = '0; end
    for (int n = 0; n < 2000; n++) begin
      logic [3:0]   req;
      logic [15:0]  lbl;
      logic [127:0] dat;
      logic         rst;
      int           w;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i]  = 1'b1;
          p_lbl[i] = 4'($urandom_range(0, 15));
          p_dat[i] = $urandom;
        end
        req[i]          = pend[i];
        lbl[i*4 +: 4]   = p_lbl[i];
        dat[i*32 +: 32] = p_dat[i];
      end
      rst = ($urandom % 50 == 0);
      w = winner(req, m_ptr);
      step(rst, req, lbl, dat);
      if (!rst && w >= 0) pend[w] = 1'b0;
    end

    // counter wrap: 65536 broadcasts from reset return bcCount to 0
    step(1'b1, 4'b0000, '0, '0);
    for (int n = 0; n < 65536; n++) step(1'b0, 4'b1111, LBL_1234, DAT_ALL);
    check("wrap_cnt", 64'(bcCount), 64'd0);
    check("wrap_err", 64'(protoErr), 64'd0);
    check("wrap_bcen", 64'(BCEN), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
